// File: rtl/spi_reg_slave.sv
// SPI slave exposing seven R/W byte registers plus a read-only status byte.
// Frame: command byte (W, addr) then one data byte; all four CKP/CPH modes.
`timescale 1ns/1ps

module spi_reg_slave #(
   parameter logic [7:0] REG_RST = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       CKP,
   input  logic       CPH,
   input  logic       SS,
   input  logic       SCK,
   input  logic       MOSI,
   output logic       MISO,
   input  logic [7:0] stat_in,
   output logic [7:0] ctrl_out,
   output logic       wr_pulse,
   output logic [2:0] wr_addr
);

   localparam logic [7:0] SYNC = 8'hA5;

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

   state_t     state;
   state_t     state_nxt;

   logic       ss_p0, ss_p1;
   logic       sck_p0, sck_p1, sck_p2;
   logic       mosi_p0, mosi_p1;
   logic       vld_p0, vld_p1;
   logic       armed;

   logic       sck_edge, lead_edge, trail_edge;
   logic       sample_edge, shift_edge;
   logic       in_frame, byte_done;

   logic [2:0] cnt;
   logic [7:0] rx_sh;
   logic [7:0] tx_sh;
   logic       miso_q;
   logic       cmd_w;
   logic [2:0] cmd_addr;
   logic       load_p;
   logic       commit_p;
   logic [7:0] rd_val;
   logic [7:0] regs [0:6];

   // Input synchronizers; vld_pN marks when the chain carries post-reset samples
   always_ff @(posedge clk) begin
      if (rst) begin
         ss_p0   <= 1'b1;
         ss_p1   <= 1'b1;
         sck_p0  <= CKP;
         sck_p1  <= CKP;
         sck_p2  <= CKP;
         mosi_p0 <= 1'b0;
         mosi_p1 <= 1'b0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         armed   <= 1'b0;
      end else begin
         ss_p0   <= SS;
         ss_p1   <= ss_p0;
         sck_p0  <= SCK;
         sck_p1  <= sck_p0;
         sck_p2  <= sck_p1;
         mosi_p0 <= MOSI;
         mosi_p1 <= mosi_p0;
         vld_p0  <= 1'b1;
         vld_p1  <= vld_p0;
         // A frame may only start after SS has genuinely been seen high
         if (vld_p1 && ss_p1) armed <= 1'b1;
      end
   end

   // Edge classification
   always_comb begin
      sck_edge    = sck_p1 ^ sck_p2;
      lead_edge   = sck_edge && (sck_p1 != CKP);
      trail_edge  = sck_edge && (sck_p1 == CKP);
      sample_edge = CPH ? trail_edge : lead_edge;
      shift_edge  = CPH ? lead_edge  : trail_edge;
      in_frame    = ((state == CMD) || (state == DATA)) && !ss_p1;
      byte_done   = in_frame && sample_edge && (cnt == 3'd7);
   end

   always_comb begin
      rd_val = stat_in;
      for (int i = 0; i < 7; i++) begin
         if (cmd_addr == i[2:0]) rd_val = regs[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (armed && !ss_p1) state_nxt = CMD;
         CMD: begin
            if (ss_p1)          state_nxt = IDLE;
            else if (byte_done) state_nxt = DATA;
         end
         DATA: begin
            if (ss_p1)          state_nxt = IDLE;
            else if (byte_done) state_nxt = DONE;
         end
         DONE: if (ss_p1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shift datapath, command decode and register commit
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= 3'd0;
         rx_sh    <= 8'h00;
         tx_sh    <= 8'h00;
         miso_q   <= 1'b0;
         cmd_w    <= 1'b0;
         cmd_addr <= 3'd0;
         load_p   <= 1'b0;
         commit_p <= 1'b0;
         wr_pulse <= 1'b0;
         wr_addr  <= 3'd0;
         for (int i = 0; i < 7; i++) regs[i] <= REG_RST;
      end else begin
         wr_pulse <= 1'b0;
         load_p   <= 1'b0;
         commit_p <= 1'b0;

         if ((state == IDLE) && (state_nxt == CMD)) begin
            cnt   <= 3'd0;
            rx_sh <= 8'h00;
            // CPH=0 has no leading shift edge, so bit 7 goes out immediately
            if (CPH) begin
               tx_sh  <= SYNC;
               miso_q <= 1'b0;
            end else begin
               tx_sh  <= {SYNC[6:0], 1'b0};
               miso_q <= SYNC[7];
            end
         end else if (in_frame) begin
            if (sample_edge) begin
               rx_sh <= {rx_sh[6:0], mosi_p1};
               cnt   <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  if (state == CMD) begin
                     cmd_w    <= rx_sh[6];
                     cmd_addr <= {rx_sh[1:0], mosi_p1};
                     load_p   <= 1'b1;
                  end else begin
                     commit_p <= 1'b1;
                  end
               end
            end
            if (shift_edge) begin
               miso_q <= tx_sh[7];
               tx_sh  <= {tx_sh[6:0], 1'b0};
            end
            if (load_p) tx_sh <= cmd_w ? 8'h00 : rd_val;
         end else begin
            cnt <= 3'd0;
         end

         if (commit_p && cmd_w && (cmd_addr != 3'd7)) begin
            for (int i = 0; i < 7; i++) begin
               if (cmd_addr == i[2:0]) regs[i] <= rx_sh;
            end
            wr_pulse <= 1'b1;
            wr_addr  <= cmd_addr;
         end
      end
   end

   assign MISO     = ((state == CMD) || (state == DATA)) ? miso_q : 1'b0;
   assign ctrl_out = regs[0];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: acts as SPI master in all four modes and
// checks MISO bytes, register contents, write pulses and reset behaviour.
`timescale 1ns/1ps

module tb_spi_reg_slave;

   localparam logic [7:0] RST_VAL = 8'h96;
   localparam int HALF = 60;

   logic       clk = 1'b0;
   logic       rst;
   logic       CKP, CPH, SS, SCK, MOSI;
   logic       MISO;
   logic [7:0] stat_in;
   logic [7:0] ctrl_out;
   logic       wr_pulse;
   logic [2:0] wr_addr;

   int n_cmp = 0;
   int n_bad = 0;
   int pulses = 0;
   int p0;
   logic [7:0] r0, r1;
   logic [7:0] vtab [4];

   spi_reg_slave #(.REG_RST(RST_VAL)) dut (
      .clk(clk), .rst(rst), .CKP(CKP), .CPH(CPH), .SS(SS), .SCK(SCK),
      .MOSI(MOSI), .MISO(MISO), .stat_in(stat_in), .ctrl_out(ctrl_out),
      .wr_pulse(wr_pulse), .wr_addr(wr_addr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (wr_pulse === 1'b1) pulses++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!CPH) begin
            MOSI = tx[i];
            #HALF;
            rx[i] = MISO;
            SCK = ~CKP;
            #HALF;
            SCK = CKP;
         end else begin
            SCK = ~CKP;
            MOSI = tx[i];
            #HALF;
            rx[i] = MISO;
            SCK = CKP;
            #HALF;
         end
      end
   endtask

   task automatic frame(input logic [7:0] c, input logic [7:0] d,
                        output logic [7:0] b0, output logic [7:0] b1);
      SS = 1'b0;
      #HALF;
      xfer(c, 8, b0);
      xfer(d, 8, b1);
      #HALF;
      SS = 1'b1;
      #(2 * HALF);
   endtask

   task automatic set_mode(input logic ckp, input logic cph);
      CKP = ckp;
      CPH = cph;
      SCK = ckp;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vtab = '{8'h3A, 8'hC6, 8'h81, 8'h7E};
      rst = 1'b1; SS = 1'b0; CKP = 1'b1; CPH = 1'b0; SCK = 1'b1; MOSI = 1'b0;
      stat_in = 8'h00;
      repeat (4) @(negedge clk);
      chk("rst_miso", MISO, 1'b0);
      chk("rst_wr_pulse", wr_pulse, 1'b0);
      chk("rst_wr_addr", wr_addr, 3'd0);
      chk("rst_ctrl_out", ctrl_out, RST_VAL);

      // SS already low when reset releases: no frame may start
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("ss_low_after_rst_miso", MISO, 1'b0);
      SS = 1'b1;
      repeat (10) @(negedge clk);

      // Write 0x3C to reg2, then read it back (CKP=1, CPH=0)
      p0 = pulses;
      frame(8'h82, 8'h3C, r0, r1);
      chk("wr2_sync", r0, 8'hA5);
      chk("wr2_data_miso", r1, 8'h00);
      chk("wr2_pulses", pulses - p0, 1);
      chk("wr2_addr", wr_addr, 3'd2);
      p0 = pulses;
      frame(8'h02, 8'hFF, r0, r1);
      chk("rd2_sync", r0, 8'hA5);
      chk("rd2_data", r1, 8'h3C);
      chk("rd2_no_pulse", pulses - p0, 0);

      // Status register: readable, writes discarded
      stat_in = 8'hC3;
      frame(8'h07, 8'h00, r0, r1);
      chk("rd7_data", r1, 8'hC3);
      p0 = pulses;
      frame(8'h87, 8'h11, r0, r1);
      chk("wr7_no_pulse", pulses - p0, 0);
      chk("wr7_addr_kept", wr_addr, 3'd2);
      frame(8'h07, 8'h00, r0, r1);
      chk("rd7_after_wr", r1, 8'hC3);

      // Aborted write to reg4 after 4 data bits
      p0 = pulses;
      SS = 1'b0;
      #HALF;
      xfer(8'h84, 8, r0);
      xfer(8'hF0, 4, r1);
      #HALF;
      SS = 1'b1;
      #(2 * HALF);
      chk("abort_no_pulse", pulses - p0, 0);
      frame(8'h04, 8'h00, r0, r1);
      chk("abort_reg4_kept", r1, RST_VAL);
      p0 = pulses;
      frame(8'h84, 8'h77, r0, r1);
      chk("after_abort_pulse", pulses - p0, 1);
      chk("after_abort_addr", wr_addr, 3'd4);
      frame(8'h04, 8'h00, r0, r1);
      chk("after_abort_rd4", r1, 8'h77);

      // Reset pulse during the data byte of a write to reg1
      p0 = pulses;
      SS = 1'b0;
      #HALF;
      xfer(8'h81, 8, r0);
      xfer(8'hAA, 3, r1);
      rst = 1'b1;
      #10;
      rst = 1'b0;
      chk("midrst_miso", MISO, 1'b0);
      chk("midrst_wr_pulse", wr_pulse, 1'b0);
      chk("midrst_wr_addr", wr_addr, 3'd0);
      chk("midrst_ctrl_out", ctrl_out, RST_VAL);
      xfer(8'h40, 5, r1);
      #HALF;
      chk("midrst_ss_low_miso", MISO, 1'b0);
      SS = 1'b1;
      #(2 * HALF);
      chk("midrst_no_pulse", pulses - p0, 0);
      frame(8'h01, 8'h00, r0, r1);
      chk("midrst_rd1", r0, 8'hA5);
      chk("midrst_reg1", r1, RST_VAL);
      frame(8'h02, 8'h00, r0, r1);
      chk("midrst_reg2", r1, RST_VAL);

      // Every CKP/CPH mode: distinct value, then 0x55, each read back
      for (int m = 0; m < 4; m++) begin
         set_mode(m[1], m[0]);
         p0 = pulses;
         frame(8'h80, vtab[m], r0, r1);
         chk($sformatf("mode%0d_wr_sync", m), r0, 8'hA5);
         chk($sformatf("mode%0d_wr_pulse", m), pulses - p0, 1);
         chk($sformatf("mode%0d_ctrl_v", m), ctrl_out, vtab[m]);
         frame(8'h00, 8'h00, r0, r1);
         chk($sformatf("mode%0d_rd_v", m), r1, vtab[m]);
         frame(8'h80, 8'h55, r0, r1);
         chk($sformatf("mode%0d_ctrl_55", m), ctrl_out, 8'h55);
         frame(8'h00, 8'hFF, r0, r1);
         chk($sformatf("mode%0d_rd_sync", m), r0, 8'hA5);
         chk($sformatf("mode%0d_rd_55", m), r1, 8'h55);
      end
      chk("idle_miso", MISO, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
